// File: rtl/timer_irq_pkg.sv
// -----------------------------------------------------------------------------
// timer_irq_pkg
// Shared constants for the memory-mapped auto-reload timer: default window
// base, register byte offsets, register indices and TCON bit positions.
// Also imported by the controller and the bus decoder, so keep it free of
// anything timer-internal.
// -----------------------------------------------------------------------------
package timer_irq_pkg;

    // Default word-aligned base of the three-register timer window.
    localparam logic [31:0] TIMER_BASE_ADDR_DEFAULT = 32'h4000_0000;

    // Byte offsets of the registers inside the window.
    localparam logic [31:0] OFF_TH   = 32'h0000_0000;
    localparam logic [31:0] OFF_TL   = 32'h0000_0004;
    localparam logic [31:0] OFF_TCON = 32'h0000_0008;

    // Register indices used for the decode/readback vectors.
    localparam int REG_IDX_TH   = 0;
    localparam int REG_IDX_TL   = 1;
    localparam int REG_IDX_TCON = 2;
    localparam int NUM_REGS     = 3;

    // TCON bit positions and implemented width.
    localparam int TCON_EN    = 0;
    localparam int TCON_IE    = 1;
    localparam int TCON_IS    = 2;
    localparam int TCON_WIDTH = 3;

    // Byte offset of a register given its index.
    function automatic logic [31:0] reg_offset(input int idx);
        logic [31:0] off;
        case (idx)
            REG_IDX_TH: off = OFF_TH;
            REG_IDX_TL: off = OFF_TL;
            default:    off = OFF_TCON;
        endcase
        return off;
    endfunction

    // Word address (Address[31:2]) of a register for a given window base.
    function automatic logic [29:0] reg_word(input logic [31:0] base, input int idx);
        logic [31:0] off;
        off = reg_offset(idx);
        return base[31:2] + off[31:2];
    endfunction

endpackage

// File: rtl/timer_irq.sv
// -----------------------------------------------------------------------------
// timer_irq
// 32-bit up-counting timer with auto-reload and a level interrupt, mapped as
// three word registers on the CPU data bus:
//   TH   (base+0) : reload value
//   TL   (base+4) : current count
//   TCON (base+8) : [0] enable, [1] interrupt enable, [2] interrupt status
//
// Ports
//   clk        : single clock, all state updates on the rising edge
//   reset      : synchronous active-high reset
//   Address    : CPU byte address (only [31:2] is decoded)
//   WriteData  : store data
//   MemRead    : load strobe
//   MemWrite   : store strobe
//   ReadData   : combinational register read data, 0 when not selected
//   IRQ        : level interrupt request, TCON.IE & TCON.IS
// -----------------------------------------------------------------------------
module timer_irq
    import timer_irq_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = TIMER_BASE_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] ReadData,
    output logic        IRQ
);

    // -------------------------------------------------------------------------
    // Register state
    // -------------------------------------------------------------------------
    logic [31:0]           th_reg,   th_next;
    logic [31:0]           tl_reg,   tl_next;
    logic [TCON_WIDTH-1:0] tcon_reg, tcon_next;

    // -------------------------------------------------------------------------
    // Address decode: one hit line per register, byte lanes ignored.
    // -------------------------------------------------------------------------
    logic [NUM_REGS-1:0] reg_hit;
    logic [31:0]         reg_value [NUM_REGS];

    // The byte-lane bits take no part in the decode.
    logic addr_lsb_unused;
    assign addr_lsb_unused = ^Address[1:0];

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_decode
            assign reg_hit[gi] = (Address[31:2] == reg_word(BASE_ADDR, gi));
        end
    endgenerate

    assign reg_value[REG_IDX_TH]   = th_reg;
    assign reg_value[REG_IDX_TL]   = tl_reg;
    assign reg_value[REG_IDX_TCON] = {{(32 - TCON_WIDTH){1'b0}}, tcon_reg};

    logic wr_th, wr_tl, wr_tcon;
    assign wr_th   = MemWrite & reg_hit[REG_IDX_TH];
    assign wr_tl   = MemWrite & reg_hit[REG_IDX_TL];
    assign wr_tcon = MemWrite & reg_hit[REG_IDX_TCON];

    // -------------------------------------------------------------------------
    // Read mux: zero latency, zero when not reading or not hitting the window.
    // -------------------------------------------------------------------------
    always_comb begin
        ReadData = 32'h0;
        if (MemRead) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (reg_hit[i]) begin
                    ReadData = reg_value[i];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Counter / reload / status next-state
    // -------------------------------------------------------------------------
    logic tl_at_top;
    logic overflow_event;

    assign tl_at_top = (tl_reg == 32'hFFFF_FFFF);

    // A CPU store to TL wins over the counter, so that cycle is not an
    // overflow at all: no reload and no status set.
    assign overflow_event = tcon_reg[TCON_EN] & tl_at_top & ~wr_tl;

    always_comb begin
        th_next   = th_reg;
        tl_next   = tl_reg;
        tcon_next = tcon_reg;

        if (wr_th) begin
            th_next = WriteData;
        end

        // Reload uses th_reg, i.e. the value before any same-cycle TH store.
        if (wr_tl) begin
            tl_next = WriteData;
        end else if (tcon_reg[TCON_EN]) begin
            tl_next = tl_at_top ? th_reg : tl_reg + 32'd1;
        end

        // Enable only takes effect from tcon_reg, so a store that sets it
        // starts counting on the following cycle.
        if (wr_tcon) begin
            tcon_next = WriteData[TCON_WIDTH-1:0];
        end

        // Applied after the store so a software clear racing an overflow
        // cannot drop the interrupt.
        if (overflow_event && tcon_reg[TCON_IE]) begin
            tcon_next[TCON_IS] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            th_reg   <= 32'h0;
            tl_reg   <= 32'h0;
            tcon_reg <= '0;
        end else begin
            th_reg   <= th_next;
            tl_reg   <= tl_next;
            tcon_reg <= tcon_next;
        end
    end

    // Purely a function of registered state; no path from the bus.
    assign IRQ = tcon_reg[TCON_IE] & tcon_reg[TCON_IS];

endmodule

// File: tb/tb_timer_irq.sv
module tb_timer_irq;

    localparam logic [31:0] BASE   = 32'h4000_0000;
    localparam logic [31:0] A_TH   = BASE;
    localparam logic [31:0] A_TL   = BASE + 32'd4;
    localparam logic [31:0] A_TCON = BASE + 32'd8;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] ReadData;
    logic        IRQ;

    int total = 0;
    int bad   = 0;

    // Reference model state (used by the randomized test)
    logic [31:0] m_th;
    logic [31:0] m_tl;
    logic [2:0]  m_tcon;

    always #5 clk = ~clk;

    timer_irq #(.BASE_ADDR(BASE)) dut (
        .clk      (clk),
        .reset    (reset),
        .Address  (Address),
        .WriteData(WriteData),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .ReadData (ReadData),
        .IRQ      (IRQ)
    );

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------ helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        Address   = a;
        WriteData = d;
        MemWrite  = 1'b1;
        tick();
        MemWrite  = 1'b0;
        Address   = 32'h0;
        $display("wr  addr=%h data=%h", a, d);
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        Address = a;
        MemRead = 1'b1;
        #1;
        d = ReadData;
        MemRead = 1'b0;
        Address = 32'h0;
        $display("rd  addr=%h data=%h", a, d);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_th = 32'h0; m_tl = 32'h0; m_tcon = 3'b000;
        $display("rst");
    endtask

    // Advance the model by n cycles of idle bus, using closed-form arithmetic:
    // count up to all-ones, one cycle to reload from TH, then cycle with period
    // (2^32 - TH).
    task automatic model_advance(input int n);
        longint unsigned to_top;
        longint unsigned rem;
        longint unsigned period;
        if (m_tcon[0] && n > 0) begin
            to_top = 64'hFFFF_FFFF - 64'(m_tl);
            if (64'(n) <= to_top) begin
                m_tl = m_tl + 32'(n);
            end else begin
                rem    = 64'(n) - to_top - 64'd1;
                period = 64'h1_0000_0000 - 64'(m_th);
                m_tl   = 32'(64'(m_th) + (rem % period));
                if (m_tcon[1]) m_tcon[2] = 1'b1;
            end
        end
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        logic [31:0] rd;
        reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Address = A_TL; WriteData = 32'hFFFF_FFFF;
        tick(); tick();
        reset = 1'b0; Address = 32'h0;
        total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b want=0", IRQ); end
        Address = A_TH; #1;
        total++; if (ReadData !== 32'h0) begin bad++; $display("FAIL reset_noread got=%h want=0", ReadData); end
        bus_read(A_TH, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL reset_th got=%h want=0", rd); end
        bus_read(A_TL, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL reset_tl got=%h want=0", rd); end
        bus_read(A_TCON, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL reset_tcon got=%h want=0", rd); end
    endtask

    task automatic test_auto_reload_and_clear();
        logic [31:0] rd;
        do_reset();
        bus_write(A_TH, 32'hFFFF_FFFD);
        bus_write(A_TL, 32'hFFFF_FFFD);
        bus_write(A_TCON, 32'h3);
        tick(); tick();
        bus_read(A_TL, rd);
        total++; if (rd !== 32'hFFFF_FFFF) begin bad++; $display("FAIL reload_pre_tl got=%h want=ffffffff", rd); end
        total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL reload_pre_irq got=%b want=0", IRQ); end
        tick();
        bus_read(A_TL, rd);
        total++; if (rd !== 32'hFFFF_FFFD) begin bad++; $display("FAIL reload_tl got=%h want=fffffffd", rd); end
        bus_read(A_TCON, rd);
        total++; if (rd !== 32'h7) begin bad++; $display("FAIL reload_tcon got=%h want=7", rd); end
        total++; if (IRQ !== 1'b1) begin bad++; $display("FAIL reload_irq got=%b want=1", IRQ); end
        // Level interrupt persists
        tick();
        total++; if (IRQ !== 1'b1) begin bad++; $display("FAIL irq_level got=%b want=1", IRQ); end
        // Clear status; counter keeps going (FFFFFFFE -> FFFFFFFF on this edge)
        bus_write(A_TCON, 32'h3);
        total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL clear_irq got=%b want=0", IRQ); end
        bus_read(A_TL, rd);
        total++; if (rd !== 32'hFFFF_FFFF) begin bad++; $display("FAIL clear_tl got=%h want=ffffffff", rd); end
        tick();
        bus_read(A_TL, rd);
        total++; if (rd !== 32'hFFFF_FFFD) begin bad++; $display("FAIL clear_next_tl got=%h want=fffffffd", rd); end
        total++; if (IRQ !== 1'b1) begin bad++; $display("FAIL clear_reraise_irq got=%b want=1", IRQ); end
    endtask

    task automatic test_lost_irq_race();
        logic [31:0] rd;
        do_reset();
        bus_write(A_TH, 32'h0000_0100);
        bus_write(A_TL, 32'hFFFF_FFFF);
        bus_write(A_TCON, 32'h7);
        bus_write(A_TCON, 32'h3);   // lands on the overflow edge
        bus_read(A_TCON, rd);
        total++; if (rd !== 32'h7) begin bad++; $display("FAIL race_tcon got=%h want=7", rd); end
        total++; if (IRQ !== 1'b1) begin bad++; $display("FAIL race_irq got=%b want=1", IRQ); end
        bus_read(A_TL, rd);
        total++; if (rd !== 32'h0000_0100) begin bad++; $display("FAIL race_tl got=%h want=100", rd); end
    endtask

    task automatic test_tl_priority();
        logic [31:0] rd;
        do_reset();
        bus_write(A_TH, 32'h0000_0200);
        bus_write(A_TL, 32'hFFFF_FFFF);
        bus_write(A_TCON, 32'h3);
        bus_write(A_TL, 32'h0000_0010);   // overflow edge
        bus_read(A_TL, rd);
        total++; if (rd !== 32'h0000_0010) begin bad++; $display("FAIL tlprio_tl got=%h want=10", rd); end
        bus_read(A_TCON, rd);
        total++; if (rd !== 32'h3) begin bad++; $display("FAIL tlprio_tcon got=%h want=3", rd); end
        tick();
        bus_read(A_TL, rd);
        total++; if (rd !== 32'h0000_0011) begin bad++; $display("FAIL tlprio_next got=%h want=11", rd); end
    endtask

    task automatic test_th_coincide();
        logic [31:0] rd;
        do_reset();
        bus_write(A_TH, 32'h0000_0300);
        bus_write(A_TL, 32'hFFFF_FFFE);
        bus_write(A_TCON, 32'h3);
        bus_write(A_TH, 32'h0000_0400);   // TL -> FFFFFFFF
        bus_write(A_TH, 32'h0000_0500);   // overflow edge
        bus_read(A_TL, rd);
        total++; if (rd !== 32'h0000_0400) begin bad++; $display("FAIL thcoin_tl got=%h want=400", rd); end
        bus_read(A_TH, rd);
        total++; if (rd !== 32'h0000_0500) begin bad++; $display("FAIL thcoin_th got=%h want=500", rd); end
        bus_read(A_TCON, rd);
        total++; if (rd !== 32'h7) begin bad++; $display("FAIL thcoin_tcon got=%h want=7", rd); end
    endtask

    task automatic test_enable_start();
        logic [31:0] rd;
        do_reset();
        bus_write(A_TL, 32'h0000_0005);
        bus_write(A_TCON, 32'h1);
        bus_read(A_TL, rd);
        total++; if (rd !== 32'h0000_0005) begin bad++; $display("FAIL en_first got=%h want=5", rd); end
        tick();
        bus_read(A_TL, rd);
        total++; if (rd !== 32'h0000_0006) begin bad++; $display("FAIL en_second got=%h want=6", rd); end
        bus_write(A_TCON, 32'h0);          // last counting edge
        tick(); tick();
        bus_read(A_TL, rd);
        total++; if (rd !== 32'h0000_0007) begin bad++; $display("FAIL en_hold got=%h want=7", rd); end
    endtask

    task automatic test_mid_reset();
        logic [31:0] rd;
        do_reset();
        bus_write(A_TH, 32'h0000_0700);
        bus_write(A_TL, 32'h0000_0020);
        bus_write(A_TCON, 32'h7);
        tick(); tick(); tick();
        do_reset();
        total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL midrst_irq got=%b want=0", IRQ); end
        bus_read(A_TH, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL midrst_th got=%h want=0", rd); end
        bus_read(A_TCON, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL midrst_tcon got=%h want=0", rd); end
        repeat (10) tick();
        bus_read(A_TL, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL midrst_tl got=%h want=0", rd); end
    endtask

    task automatic test_decode();
        logic [31:0] rd;
        do_reset();
        bus_write(A_TH, 32'h1234_5678);
        bus_write(A_TL, 32'hCAFE_0000);
        bus_write(A_TCON, 32'h2);
        bus_read(BASE + 32'd12, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL dec_unused_rd got=%h want=0", rd); end
        bus_write(BASE + 32'd16, 32'hFFFF_FFFF);
        bus_write(BASE + 32'd12, 32'hFFFF_FFFF);
        bus_write(BASE - 32'd4,  32'hFFFF_FFFF);
        bus_read(A_TH, rd);
        total++; if (rd !== 32'h1234_5678) begin bad++; $display("FAIL dec_th got=%h want=12345678", rd); end
        bus_read(A_TL, rd);
        total++; if (rd !== 32'hCAFE_0000) begin bad++; $display("FAIL dec_tl got=%h want=cafe0000", rd); end
        bus_read(A_TCON, rd);
        total++; if (rd !== 32'h2) begin bad++; $display("FAIL dec_tcon got=%h want=2", rd); end
        bus_read(BASE + 32'd1, rd);
        total++; if (rd !== 32'h1234_5678) begin bad++; $display("FAIL dec_bytelane got=%h want=12345678", rd); end
        // Hits the window but no read strobe
        Address = A_TL; #1;
        total++; if (ReadData !== 32'h0) begin bad++; $display("FAIL dec_noread got=%h want=0", ReadData); end
        Address = 32'h0;
        // Upper TCON bits ignore writes
        bus_write(A_TCON, 32'hFFFF_FFF8);
        bus_read(A_TCON, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL dec_tcon_hi got=%h want=0", rd); end
    endtask

    task automatic test_random();
        logic [31:0] rd;
        logic [31:0] th, tl;
        logic [2:0]  tc;
        int          n;
        for (int it = 0; it < 25; it++) begin
            do_reset();
            th = ($urandom_range(0, 3) != 0) ? 32'hFFFF_FFFF - $urandom_range(0, 15) : $urandom;
            tl = ($urandom_range(0, 3) != 0) ? 32'hFFFF_FFFF - $urandom_range(0, 40) : $urandom;
            tc = 3'($urandom_range(0, 7));
            n  = $urandom_range(0, 60);
            bus_write(A_TH, th);
            bus_write(A_TL, tl);
            bus_write(A_TCON, {29'h0, tc});
            m_th = th; m_tl = tl; m_tcon = tc;
            repeat (n) tick();
            model_advance(n);
            $display("rand it=%0d th=%h tl=%h tcon=%0d n=%0d", it, th, tl, tc, n);
            bus_read(A_TL, rd);
            total++; if (rd !== m_tl) begin bad++; $display("FAIL rand_tl it=%0d got=%h want=%h", it, rd, m_tl); end
            bus_read(A_TCON, rd);
            total++; if (rd !== {29'h0, m_tcon}) begin bad++; $display("FAIL rand_tcon it=%0d got=%h want=%h", it, rd, m_tcon); end
            bus_read(A_TH, rd);
            total++; if (rd !== m_th) begin bad++; $display("FAIL rand_th it=%0d got=%h want=%h", it, rd, m_th); end
            total++; if (IRQ !== (m_tcon[1] & m_tcon[2])) begin bad++; $display("FAIL rand_irq it=%0d got=%b want=%b", it, IRQ, m_tcon[1] & m_tcon[2]); end
        end
    endtask

    initial begin
        reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Address = 32'h0; WriteData = 32'h0;
        m_th = 32'h0; m_tl = 32'h0; m_tcon = 3'b000;
        test_reset();
        test_auto_reload_and_clear();
        test_lost_irq_race();
        test_tl_priority();
        test_th_coincide();
        test_enable_start();
        test_mid_reset();
        test_decode();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/timer_irq.md
TIMER_IRQ -- requirements
Module: timer_irq

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h4000_0000: word-aligned base of the 3-register timer window.
REQ-002 SHALL have port clk  input  1: single clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-004 SHALL have port Address  input  32: byte address from the CPU data bus.
REQ-005 SHALL have port WriteData  input  32: store data from the CPU.
REQ-006 SHALL have port MemRead  input  1: load strobe from the controller.
REQ-007 SHALL have port MemWrite  input  1: store strobe from the controller.
REQ-008 SHALL have port ReadData  output  32: register read data.
REQ-009 SHALL have port IRQ  output  1: interrupt request to the controller.

Function
REQ-010 SHALL decode TH at BASE_ADDR+0, TL at BASE_ADDR+4 and TCON at BASE_ADDR+8, using Address[31:2] only.
REQ-011 SHALL define the TCON bits as: [0] enable, [1] interrupt-enable, [2] interrupt status. Bits [31:3] read as 0 and ignore writes.
REQ-012 SHALL drive ReadData combinationally (zero latency): the selected register when MemRead=1 and the address hits, otherwise 32'h0.
REQ-013 SHALL capture the full WriteData into TH or TL on the clock edge when MemWrite=1 and the address hits.
REQ-014 SHALL write TCON[2:0] from WriteData[2:0] on a TCON hit.
REQ-015 SHALL increment TL by 1 each cycle while TCON[0]=1 and TL≠32'hFFFF_FFFF, with no prescaler.
REQ-016 SHALL, on an enabled cycle with TL=32'hFFFF_FFFF, reload TL<=TH and set TCON[2]<=1 if TCON[1]=1. This is the overflow event.
REQ-017 SHALL hold TL and TCON[2] unchanged while TCON[0]=0.
REQ-018 SHALL drive IRQ = TCON[1] & TCON[2] as a registered-state function, with no combinational path from bus inputs.
REQ-019 SHALL give a CPU write to TL priority over both increment and reload in the same cycle.
REQ-020 SHALL, when a CPU write to TH coincides with overflow, reload TL from the old TH value.
REQ-021 SHALL, when a TCON write clearing bit 2 coincides with an overflow that sets it, leave TCON[2]=1 so no interrupt is lost. Bits [1:0] still take the written value.
REQ-022 SHALL, when a TCON write setting bit 0 coincides with anything else, begin counting on the following cycle.
REQ-023 SHALL keep IRQ asserted (level, not pulse) until software clears TCON[2] or TCON[1].
REQ-024 SHALL ignore MemWrite or MemRead to addresses outside the window, and also the unused offset BASE_ADDR+12.

Reset
REQ-025 SHALL reset TH, TL and TCON to 0 when reset=1 on a clock edge, overriding any concurrent write or overflow.
REQ-026 SHALL make IRQ=0 in the cycle after reset, with ReadData following REQ-012 from the reset state.
REQ-027 SHALL abandon any count in progress on a mid-operation reset, so counting resumes only after software re-enables it.

Structure
REQ-028 SHALL put the register offsets, the TCON bit indices (TCON_EN=0, TCON_IE=1, TCON_IS=2) and the default BASE_ADDR in a shared package, which the controller and bus decoder also use.
REQ-029 SHALL be a single flat module with no sub-modules; the counter is too small to justify a separate block.

Verification
REQ-030 SHALL cover auto-reload: write TH=32'hFFFF_FFFD, TL=32'hFFFF_FFFD, TCON=3. After the 3rd enabled edge TL=32'hFFFF_FFFD, TCON=7 and IRQ=1.
REQ-031 SHALL cover interrupt clear: with IRQ=1, write TCON=3. Next cycle IRQ=0, and counting continues from its current value.
REQ-032 SHALL cover the lost-interrupt race: with TL=32'hFFFF_FFFF, TCON=7, write TCON=3 on the overflow edge. TCON reads 7 and IRQ stays 1.
REQ-033 SHALL cover TL write priority: on the overflow edge write TL=32'h10. Next cycle TL=32'h10 and TCON[2] is unchanged.
REQ-034 SHALL cover mid-operation reset: with TCON=7 and counting, pulse reset for 1 cycle. TH=TL=TCON=0, IRQ=0 and TL stays 0 for 10 cycles.
REQ-035 SHALL cover decode: with MemRead=1, Address=BASE_ADDR+12 gives ReadData=0, and a write to BASE_ADDR+16 leaves all registers unchanged.
